mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter N, default 64: data and address width.
REQ-002 Parameter MEM_BYTES, default 65536: data-memory size in bytes.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 e_valid  in  1  execute stage presents an instruction.
REQ-006 e_ready  out  1  block accepts the instruction this cycle.
REQ-007 e_icode  in  4  Y86-64 instruction code.
REQ-008 e_stat  in  3  incoming status code.
REQ-009 e_valE, e_valA  in  N  ALU result; register A value / valP.
REQ-010 e_dstE, e_dstM  in  4  destination registers (0xF = none).
REQ-011 dm_add, dm_wdata  out  N  data-memory address and write data.
REQ-012 dm_ren, dm_wen  out  1  data-memory read and write enables.
REQ-013 dm_rdata  in  N  read data; dm_err  in  1  memory error; both valid the cycle after the request cycle.
REQ-014 w_valid  out  1  writeback bundle valid; w_ready  in  1  writeback accepts.
REQ-015 w_icode 4, w_stat 3, w_valE N, w_valM N, w_dstE 4, w_dstM 4  out  registered writeback bundle.

Function
REQ-016 FSM states: IDLE, ACCESS, RESP, OUT, HALT; e_ready SHALL be 1 only in IDLE.
REQ-017 Accept occurs on e_valid & e_ready; all e_* fields are latched on accept.
REQ-018 Access decode: rmmovq(4), call(8), pushq(A) write dm_add=valE, dm_wdata=valA; mrmovq(5) reads dm_add=valE; ret(9), popq(B) read dm_add=valA; all other icodes make no access.
REQ-019 An accepted instruction with e_stat != AOK(1) or a no-access icode goes IDLE->OUT; w_valid is asserted the cycle after accept, w_valM=0.
REQ-020 A memory instruction goes IDLE->ACCESS->RESP->OUT; dm_ren or dm_wen is asserted for exactly the ACCESS cycle; w_valid is asserted 3 cycles after accept.
REQ-021 dm_ren and dm_wen SHALL never be high together; both are 0 outside ACCESS; dm_add and dm_wdata are 0 outside ACCESS.
REQ-022 In RESP, dm_rdata is captured into w_valM for reads; for writes w_valM=0.
REQ-023 dm_err=1 in RESP forces w_stat=ADR(3) and w_valM=0.
REQ-024 Addresses with valE/valA + 7 >= MEM_BYTES SHALL still be issued; the error is reported solely through dm_err.
REQ-025 The latched w_* bundle is held stable while w_valid=1 and w_ready=0.
REQ-026 OUT -> IDLE on w_ready when w_stat=AOK; OUT -> HALT on w_ready when w_stat != AOK.
REQ-027 HALT is absorbing: e_ready=0, w_valid=0, and no memory access occurs until reset.
REQ-028 w_valE, w_dstE, w_dstM, and w_icode pass through unchanged from the latched inputs.

Reset
REQ-029 On reset, the state is IDLE; e_ready=1 in the following cycle; w_valid, dm_ren, and dm_wen are 0; all w_* and dm_* data outputs are 0.
REQ-030 Reset in any state, including HALT, returns to IDLE and drops any in-flight instruction without a W output.
REQ-031 A write whose ACCESS cycle coincides with reset is committed by memory; no W output is produced for it.

Structure
REQ-032 Package y86_pkg SHALL hold icode constants, stat codes (AOK=1, HLT=2, ADR=3, INS=4), the REG_NONE=0xF constant, and the mem_stage state enum.
REQ-033 One combinational sub-module, mem_ctrl_decode, SHALL map icode to {ren, wen, addr_sel} and be reused by the hazard unit.

Verification
REQ-034 Reset, then rmmovq with valE=0x100, valA=0xDEADBEEF -> one-cycle dm_wen, dm_add=0x100, dm_wdata=0xDEADBEEF; w_valid 3 cycles later, w_stat=1.
REQ-035 mrmovq with valE=0x100 after the write above -> dm_ren for one cycle; w_valM=0xDEADBEEF.
REQ-036 popq with valA=0xFFFC (dm_err=1) -> w_stat=3, w_valM=0; after w_ready the block enters HALT and holds e_ready=0 for 10 cycles while e_valid=1.
REQ-037 opq (icode 6) with valE=5 -> no dm enable; w_valid the next cycle with w_valE=5.
REQ-038 w_ready held 0 for 4 cycles during OUT -> w_* stable and e_ready=0; the handshake completes on the first w_ready=1.
REQ-039 Reset asserted during ACCESS of pushq -> no w_valid; e_ready=1 the cycle after reset deasserts; dm_ren and dm_wen are never both 1 throughout.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants for the memory stage: instruction codes, status
// codes, the "no register" marker and the memory-stage FSM encoding.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP,
    S_OUT,
    S_HALT
  } mem_state_e;

  // Which latched operand drives the data-memory address.
  typedef enum logic {
    ADDR_VALE,
    ADDR_VALA
  } addr_sel_e;

endpackage

// File: rtl/mem_stage_if.sv
// Execute-in, data-memory and writeback-out signals of the memory stage.
// The stage itself uses the slave view; the surrounding pipeline uses master.
interface mem_stage_if #(
  parameter int N = 64
);

  logic         e_valid;
  logic         e_ready;
  logic [3:0]   e_icode;
  logic [2:0]   e_stat;
  logic [N-1:0] e_valE;
  logic [N-1:0] e_valA;
  logic [3:0]   e_dstE;
  logic [3:0]   e_dstM;

  logic [N-1:0] dm_add;
  logic [N-1:0] dm_wdata;
  logic         dm_ren;
  logic         dm_wen;
  logic [N-1:0] dm_rdata;
  logic         dm_err;

  logic         w_valid;
  logic         w_ready;
  logic [3:0]   w_icode;
  logic [2:0]   w_stat;
  logic [N-1:0] w_valE;
  logic [N-1:0] w_valM;
  logic [3:0]   w_dstE;
  logic [3:0]   w_dstM;

  modport slave (
    input  e_valid, e_icode, e_stat, e_valE, e_valA, e_dstE, e_dstM,
    output e_ready,
    output dm_add, dm_wdata, dm_ren, dm_wen,
    input  dm_rdata, dm_err,
    output w_valid, w_icode, w_stat, w_valE, w_valM, w_dstE, w_dstM,
    input  w_ready
  );

  modport master (
    output e_valid, e_icode, e_stat, e_valE, e_valA, e_dstE, e_dstM,
    input  e_ready,
    input  dm_add, dm_wdata, dm_ren, dm_wen,
    output dm_rdata, dm_err,
    input  w_valid, w_icode, w_stat, w_valE, w_valM, w_dstE, w_dstM,
    output w_ready
  );

endinterface

// File: rtl/mem_ctrl_decode.sv
// Maps a Y86-64 icode to its data-memory action; shared with the hazard unit
// so both agree on which instructions touch memory.
module mem_ctrl_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic       ren_o,
  output logic       wen_o,
  output addr_sel_e  addr_sel_o
);

  // NOTE: every output gets a default before the case so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    ren_o      = 1'b0;
    wen_o      = 1'b0;
    addr_sel_o = ADDR_VALE;
    case (icode_i)
      I_RMMOVQ, I_CALL, I_PUSHQ: wen_o = 1'b1;
      I_MRMOVQ:                  ren_o = 1'b1;
      I_RET, I_POPQ: begin
        ren_o      = 1'b1;
        addr_sel_o = ADDR_VALA;
      end
      I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_OPQ, I_JXX: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Y86-64 memory stage: accepts one instruction at a time from execute,
// performs at most one data-memory access and hands a registered bundle on.
module mem_stage
  import y86_pkg::*;
#(
  parameter int N         = 64,
  parameter int MEM_BYTES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave bus
);

  // Out-of-range addresses are still issued; memory flags them via dm_err.
  if (MEM_BYTES < 8) begin : g_bad_mem_bytes
    $error("mem_stage: MEM_BYTES must hold at least one 8-byte word");
  end

  mem_state_e   state_q, state_d;

  logic [3:0]   icode_q;
  logic [2:0]   stat_q;
  logic [N-1:0] valE_q;
  logic [N-1:0] valA_q;
  logic [N-1:0] valM_q;
  logic [3:0]   dstE_q;
  logic [3:0]   dstM_q;
  logic         ren_q;
  logic         wen_q;
  addr_sel_e    sel_q;

  logic         dec_ren;
  logic         dec_wen;
  addr_sel_e    dec_sel;
  logic         accept;
  logic         needs_access;

  mem_ctrl_decode u_decode (
    .icode_i   (bus.e_icode),
    .ren_o     (dec_ren),
    .wen_o     (dec_wen),
    .addr_sel_o(dec_sel)
  );

  assign accept       = bus.e_valid & bus.e_ready;
  assign needs_access = (bus.e_stat == STAT_AOK) & (dec_ren | dec_wen);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept) state_d = needs_access ? S_ACCESS : S_OUT;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_OUT;
      S_OUT:    if (bus.w_ready) state_d = (stat_q == STAT_AOK) ? S_IDLE : S_HALT;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.e_ready  = 1'b0;
    bus.w_valid  = 1'b0;
    bus.dm_ren   = 1'b0;
    bus.dm_wen   = 1'b0;
    bus.dm_add   = '0;
    bus.dm_wdata = '0;
    unique case (state_q)
      S_IDLE:   bus.e_ready = 1'b1;
      S_ACCESS: begin
        bus.dm_ren   = ren_q;
        bus.dm_wen   = wen_q;
        bus.dm_add   = (sel_q == ADDR_VALA) ? valA_q : valE_q;
        bus.dm_wdata = wen_q ? valA_q : '0;
      end
      S_OUT:    bus.w_valid = 1'b1;
      default: ;
    endcase
  end

  // NOTE: the datapath is reset too, because the writeback bundle must read
  // as zero straight out of reset, not merely be marked invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      icode_q <= '0;
      stat_q  <= '0;
      valE_q  <= '0;
      valA_q  <= '0;
      valM_q  <= '0;
      dstE_q  <= '0;
      dstM_q  <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      sel_q   <= ADDR_VALE;
    end else begin
      if (accept) begin
        icode_q <= bus.e_icode;
        stat_q  <= bus.e_stat;
        valE_q  <= bus.e_valE;
        valA_q  <= bus.e_valA;
        valM_q  <= '0;
        dstE_q  <= bus.e_dstE;
        dstM_q  <= bus.e_dstM;
        ren_q   <= dec_ren;
        wen_q   <= dec_wen;
        sel_q   <= dec_sel;
      end
      // Memory answers the cycle after the request, i.e. while in RESP.
      if (state_q == S_RESP) begin
        if (bus.dm_err) begin
          stat_q <= STAT_ADR;
          valM_q <= '0;
        end else if (ren_q) begin
          valM_q <= bus.dm_rdata;
        end
      end
    end
  end

  assign bus.w_icode = icode_q;
  assign bus.w_stat  = stat_q;
  assign bus.w_valE  = valE_q;
  assign bus.w_valM  = valM_q;
  assign bus.w_dstE  = dstE_q;
  assign bus.w_dstM  = dstM_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: a behavioural data memory, a reference
// memory model and a scoreboard of expected writeback bundles.
module tb_mem_stage;
  import y86_pkg::*;

  localparam int N           = 64;
  localparam int MEM_BYTES   = 65536;
  localparam int MEM_WORDS   = MEM_BYTES / 8;
  localparam int CYCLE_LIMIT = 50;

  typedef struct packed {
    logic [3:0]   icode;
    logic [2:0]   stat;
    logic [N-1:0] valE;
    logic [N-1:0] valM;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
  } wb_t;

  logic clk;
  logic reset;

  mem_stage_if #(.N(N)) bus ();

  mem_stage #(.N(N), .MEM_BYTES(MEM_BYTES)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int both_hi  = 0;

  wb_t          sb_q[$];
  logic [N-1:0] mem     [MEM_WORDS];
  logic [N-1:0] ref_mem [MEM_WORDS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit addr_err(input logic [N-1:0] a);
    logic [N-1:0] lim;
    lim = MEM_BYTES - 8;
    return a > lim;
  endfunction

  function automatic int widx(input logic [N-1:0] a);
    return int'(a >> 3);
  endfunction

  // Behavioural data memory: answers the cycle after each request.
  always @(posedge clk) begin
    bus.dm_err   <= 1'b0;
    bus.dm_rdata <= '0;
    if (bus.dm_ren || bus.dm_wen) begin
      bus.dm_err <= addr_err(bus.dm_add);
      if (!addr_err(bus.dm_add)) begin
        if (bus.dm_wen) mem[widx(bus.dm_add)] <= bus.dm_wdata;
        if (bus.dm_ren) bus.dm_rdata <= mem[widx(bus.dm_add)];
      end
    end
  end

  // Output monitor: exclusivity of enables and scoreboard comparison.
  always @(negedge clk) begin
    if (bus.dm_ren && bus.dm_wen) both_hi++;
    if (!reset && bus.w_valid && bus.w_ready) begin
      if (sb_q.size() == 0) begin
        check("w_unexpected", bus.w_valid, 1'b0);
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        check("w_icode", bus.w_icode, e.icode);
        check("w_stat",  bus.w_stat,  e.stat);
        check("w_valE",  bus.w_valE,  e.valE);
        check("w_valM",  bus.w_valM,  e.valM);
        check("w_dstE",  bus.w_dstE,  e.dstE);
        check("w_dstM",  bus.w_dstM,  e.dstM);
      end
    end
  end

  // Drive one instruction until accepted and push its expected bundle.
  task automatic send(input logic [3:0] ic, input logic [2:0] st,
                      input logic [N-1:0] ve, input logic [N-1:0] va,
                      input logic [3:0] de, input logic [3:0] dm,
                      output bit accepted, output bit rd, output bit wr,
                      output logic [N-1:0] addr);
    wb_t e;
    int  waited;
    rd   = (ic == I_MRMOVQ) || (ic == I_RET) || (ic == I_POPQ);
    wr   = (ic == I_RMMOVQ) || (ic == I_CALL) || (ic == I_PUSHQ);
    addr = ((ic == I_RET) || (ic == I_POPQ)) ? va : ve;
    if (st != STAT_AOK) begin
      rd = 1'b0;
      wr = 1'b0;
    end
    accepted = 1'b0;
    @(posedge clk); #1;
    bus.e_valid = 1'b1;
    bus.e_icode = ic;
    bus.e_stat  = st;
    bus.e_valE  = ve;
    bus.e_valA  = va;
    bus.e_dstE  = de;
    bus.e_dstM  = dm;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.e_ready) break;
      waited++;
      if (waited >= CYCLE_LIMIT) begin
        check("accept_timeout", 1'b0, 1'b1);
        bus.e_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    accepted = 1'b1;
    // Scramble the inputs so anything not latched on accept shows up.
    bus.e_valid = 1'b0;
    bus.e_icode = 4'($urandom);
    bus.e_stat  = 3'($urandom);
    bus.e_valE  = {$urandom, $urandom};
    bus.e_valA  = {$urandom, $urandom};
    bus.e_dstE  = 4'($urandom);
    bus.e_dstM  = 4'($urandom);

    e.icode = ic;
    e.valE  = ve;
    e.dstE  = de;
    e.dstM  = dm;
    e.stat  = st;
    e.valM  = '0;
    if ((rd || wr) && addr_err(addr)) begin
      e.stat = STAT_ADR;
    end else if (rd) begin
      e.valM = ref_mem[widx(addr)];
    end else if (wr) begin
      ref_mem[widx(addr)] = va;
    end
    sb_q.push_back(e);
  endtask

  // Send and check the per-cycle enable/valid timeline up to w_valid.
  task automatic issue(input logic [3:0] ic, input logic [2:0] st,
                       input logic [N-1:0] ve, input logic [N-1:0] va,
                       input logic [3:0] de, input logic [3:0] dm);
    bit acc, rd, wr;
    logic [N-1:0] a;
    send(ic, st, ve, va, de, dm, acc, rd, wr, a);
    if (!acc) return;
    @(negedge clk);
    if (rd || wr) begin
      check("acc_dm_ren",   bus.dm_ren, rd);
      check("acc_dm_wen",   bus.dm_wen, wr);
      check("acc_dm_add",   bus.dm_add, a);
      check("acc_dm_wdata", bus.dm_wdata, wr ? va : '0);
      check("acc_e_ready",  bus.e_ready, 1'b0);
      @(negedge clk);
      check("resp_dm_en", {bus.dm_ren, bus.dm_wen}, 2'b00);
      check("resp_w_valid", bus.w_valid, 1'b0);
      @(negedge clk);
    end else begin
      check("noacc_dm_en", {bus.dm_ren, bus.dm_wen}, 2'b00);
    end
    check("out_w_valid", bus.w_valid, 1'b1);
    check("out_dm_add",  bus.dm_add, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
  endtask

  task automatic check_halt(input string tag);
    @(posedge clk); #1;
    bus.e_valid = 1'b1;
    bus.e_icode = I_OPQ;
    bus.e_stat  = STAT_AOK;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check({tag, "_e_ready"}, bus.e_ready, 1'b0);
      check({tag, "_w_valid"}, bus.w_valid, 1'b0);
      check({tag, "_dm_en"}, {bus.dm_ren, bus.dm_wen}, 2'b00);
    end
    bus.e_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit acc, rd, wr;
    logic [N-1:0] a;

    reset       = 1'b1;
    bus.e_valid = 1'b0;
    bus.e_icode = '0;
    bus.e_stat  = '0;
    bus.e_valE  = '0;
    bus.e_valA  = '0;
    bus.e_dstE  = '0;
    bus.e_dstM  = '0;
    bus.w_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_e_ready", bus.e_ready, 1'b1);
    check("rst_w_valid", bus.w_valid, 1'b0);
    check("rst_dm_en",   {bus.dm_ren, bus.dm_wen}, 2'b00);
    check("rst_dm_add",  bus.dm_add, '0);
    check("rst_dm_wdata", bus.dm_wdata, '0);
    check("rst_w_bundle", {bus.w_icode, bus.w_stat, bus.w_dstE, bus.w_dstM}, '0);
    check("rst_w_valE",  bus.w_valE, '0);
    check("rst_w_valM",  bus.w_valM, '0);

    // Write then read back, plus stack-style access via valA.
    issue(I_RMMOVQ, STAT_AOK, 64'h100, 64'hDEAD_BEEF, REG_NONE, REG_NONE);
    issue(I_MRMOVQ, STAT_AOK, 64'h100, 64'h0, REG_NONE, 4'h3);
    issue(I_CALL,   STAT_AOK, 64'hFFF8, 64'h1234, 4'h4, REG_NONE);
    issue(I_RET,    STAT_AOK, 64'h1_0000, 64'hFFF8, 4'h4, REG_NONE);
    issue(I_PUSHQ,  STAT_AOK, 64'h200, 64'hCAFE, 4'h4, REG_NONE);
    issue(I_POPQ,   STAT_AOK, 64'h208, 64'h200, 4'h4, 4'h1);
    issue(I_OPQ,    STAT_AOK, 64'h5, 64'h9, 4'h2, REG_NONE);

    // Back-pressure: the bundle must hold while w_ready is low.
    @(posedge clk); #1;
    bus.w_ready = 1'b0;
    issue(I_OPQ, STAT_AOK, 64'h7, 64'h0, 4'h4, REG_NONE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_w_valid", bus.w_valid, 1'b1);
      check("stall_e_ready", bus.e_ready, 1'b0);
      check("stall_w_valE",  bus.w_valE, 64'h7);
      check("stall_w_misc",  {bus.w_icode, bus.w_stat, bus.w_dstE, bus.w_dstM},
            {I_OPQ, STAT_AOK, 4'h4, REG_NONE});
      check("stall_w_valM",  bus.w_valM, '0);
    end
    @(posedge clk); #1;
    bus.w_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_done_w_valid", bus.w_valid, 1'b0);
    check("stall_done_e_ready", bus.e_ready, 1'b1);
    check("stall_sb_empty", sb_q.size(), 0);

    // Memory error on pop -> ADR, then absorbing HALT.
    issue(I_POPQ, STAT_AOK, 64'h4, 64'hFFFC, 4'h4, 4'h2);
    check_halt("halt_adr");
    do_reset();
    @(negedge clk);
    check("post_halt_e_ready", bus.e_ready, 1'b1);

    // Incoming bad status skips memory even for a load, then halts.
    issue(I_MRMOVQ, STAT_INS, 64'h100, 64'h0, REG_NONE, 4'h5);
    check_halt("halt_ins");
    do_reset();

    // Last legal word is fine, one byte further is not.
    issue(I_RMMOVQ, STAT_AOK, 64'hFFF8, 64'h55AA, REG_NONE, REG_NONE);
    issue(I_RMMOVQ, STAT_AOK, 64'hFFF9, 64'h77, REG_NONE, REG_NONE);
    check_halt("halt_oob_write");
    do_reset();

    // Reset landing on the ACCESS cycle of a push.
    send(I_PUSHQ, STAT_AOK, 64'h300, 64'hBEEF_0001, 4'h4, REG_NONE, acc, rd, wr, a);
    reset = 1'b1;
    @(negedge clk);
    check("rst_access_dm_wen", bus.dm_wen, 1'b1);
    check("rst_access_dm_ren", bus.dm_ren, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("rst_access_e_ready", bus.e_ready, 1'b1);
    check("rst_access_w_valid", bus.w_valid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_access_no_w", bus.w_valid, 1'b0);
    end
    check("push_committed", mem[widx(64'h300)], 64'hBEEF_0001);

    issue(I_MRMOVQ, STAT_AOK, 64'h300, 64'h0, REG_NONE, 4'h6);
    issue(I_OPQ, STAT_AOK, 64'h0, 64'h0, 4'h0, REG_NONE);
    @(negedge clk);
    @(negedge clk);

    check("dm_exclusive", both_hi, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
